// File: rtl/xnor_cmp_pkg.sv
// Shared defaults, popcount-width helper and result layout for the XNOR comparator pipeline.
package xnor_cmp_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

  // Width needed to hold a count of 0..width matching bits.
  function automatic int pc_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Reduce-stage result at the default operand width. `xnor` is a reserved
  // word, so the vector field is named xnor_bits.
  typedef struct packed {
    logic [WIDTH_DEF-1:0]             xnor_bits;
    logic [$clog2(WIDTH_DEF + 1)-1:0] popcnt;
    logic                             eq;
  } result_t;

endpackage

// File: rtl/xnor_cmp_popcnt.sv
// Combinational adder-tree popcount. Leaves are padded to a power of two with zeros.
module xnor_cmp_popcnt
  import xnor_cmp_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int PC_W  = pc_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [PC_W-1:0]  count
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int LEAVES = 1 << LEVELS;

  // Level l holds LEAVES>>l partial sums. Every partial sum is at most WIDTH,
  // so PC_W bits are enough at every level.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [PC_W-1:0] sum [LEAVES >> l];
    for (genvar j = 0; j < (LEAVES >> l); j++) begin : g_node
      if (l == 0) begin : g_leaf
        if (j < WIDTH) begin : g_bit
          assign sum[j] = PC_W'(vec[j]);
        end else begin : g_pad
          assign sum[j] = '0;
        end
      end else begin : g_add
        assign sum[j] = g_lvl[l-1].sum[2*j] + g_lvl[l-1].sum[2*j+1];
      end
    end
  end

  assign count = g_lvl[LEVELS].sum[0];

endmodule

// File: rtl/xnor_cmp_pipe.sv
// Two-stage valid/ready XNOR comparator with a saturating equal-result counter.
// Optional per-bit mask port enabled by defining XNOR_CMP_MASK_EN.
module xnor_cmp_pipe
  import xnor_cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int PC_W  = pc_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef XNOR_CMP_MASK_EN
  input  logic [WIDTH-1:0] mask_i,
`endif
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] xnor_o,
  output logic [PC_W-1:0]  popcnt_o,
  output logic             eq_o,
  input  logic             clear_i,
  output logic [CNT_W-1:0] eq_cnt_o
);

  // Same layout as result_t, sized for this instance's WIDTH.
  typedef struct packed {
    logic [WIDTH-1:0] xnor_bits;
    logic [PC_W-1:0]  popcnt;
    logic             eq;
  } stage2_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_v;
  logic [WIDTH-1:0] s1_x;
  logic             s2_v;
  stage2_t          s2;
  logic [CNT_W-1:0] eq_cnt;

  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] x_d;
  logic [PC_W-1:0]  pc_d;

  assign s2_adv  = !s2_v || ready_i;
  assign s1_adv  = !s1_v || s2_adv;
  assign ready_o = s1_adv;

  always_comb begin
    // NOTE: combinational outputs get a default first so no path can infer a latch.
    x_d = ~(a_i ^ b_i);
`ifdef XNOR_CMP_MASK_EN
    x_d = x_d | mask_i;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_x <= '0;
    end else if (s1_adv) begin
      s1_v <= valid_i;
      if (valid_i) s1_x <= x_d;
    end
  end

  xnor_cmp_popcnt #(.WIDTH(WIDTH)) u_popcnt (
    .vec   (s1_x),
    .count (pc_d)
  );

  // NOTE: data registers are reset too, because the result outputs have defined reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0;
      s2   <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2.xnor_bits <= s1_x;
        s2.popcnt    <= pc_d;
        s2.eq        <= &s1_x;
      end
    end
  end

  // Clear has priority over an incrementing transfer in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_cnt <= '0;
    end else if (clear_i) begin
      eq_cnt <= '0;
    end else if (s2_v && ready_i && s2.eq && (eq_cnt != CNT_MAX)) begin
      eq_cnt <= eq_cnt + CNT_W'(1);
    end
  end

  assign valid_o  = s2_v;
  assign xnor_o   = s2.xnor_bits;
  assign popcnt_o = s2.popcnt;
  assign eq_o     = s2.eq;
  assign eq_cnt_o = eq_cnt;

endmodule

// File: tb/tb_xnor_cmp_pipe.sv
// Scoreboard bench for xnor_cmp_pipe: a driver queues hand-computed results, a monitor pops
// and compares on every output transfer. A CNT_W=2 instance shares the stimulus.
module tb_xnor_cmp_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        ready_o, valid_o, eq_o;
  logic [31:0] xnor_o;
  logic [5:0]  popcnt_o;
  logic [15:0] eq_cnt_o;

  logic        sat_ready_o, sat_valid_o, sat_eq_o;
  logic [31:0] sat_xnor_o;
  logic [5:0]  sat_popcnt_o;
  logic [1:0]  sat_cnt_o;

`ifdef XNOR_CMP_MASK_EN
  logic [31:0] mask = '0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] x;
    logic [5:0]  pc;
    logic        eq;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  xnor_cmp_pipe #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .ready_o(ready_o), .a_i(a), .b_i(b),
`ifdef XNOR_CMP_MASK_EN
    .mask_i(mask),
`endif
    .valid_o(valid_o), .ready_i(ready), .xnor_o(xnor_o), .popcnt_o(popcnt_o), .eq_o(eq_o),
    .clear_i(clear), .eq_cnt_o(eq_cnt_o)
  );

  xnor_cmp_pipe #(.WIDTH(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .ready_o(sat_ready_o), .a_i(a), .b_i(b),
`ifdef XNOR_CMP_MASK_EN
    .mask_i(mask),
`endif
    .valid_o(sat_valid_o), .ready_i(ready), .xnor_o(sat_xnor_o), .popcnt_o(sat_popcnt_o),
    .eq_o(sat_eq_o), .clear_i(clear), .eq_cnt_o(sat_cnt_o)
  );

`ifdef XNOR_CMP_MASK_EN
  logic       m_valid = 1'b0;
  logic [7:0] m_a = '0, m_b = '0, m_mask = '0;
  logic       m_ready_o, m_valid_o, m_eq_o;
  logic [7:0] m_xnor_o;
  logic [3:0] m_popcnt_o;
  logic [3:0] m_cnt_o;

  xnor_cmp_pipe #(.WIDTH(8), .CNT_W(4)) dut_m (
    .clk(clk), .rst_n(rst_n), .valid_i(m_valid), .ready_o(m_ready_o), .a_i(m_a), .b_i(m_b),
    .mask_i(m_mask), .valid_o(m_valid_o), .ready_i(1'b1), .xnor_o(m_xnor_o),
    .popcnt_o(m_popcnt_o), .eq_o(m_eq_o), .clear_i(1'b0), .eq_cnt_o(m_cnt_o)
  );
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the operands.
  task automatic send(input logic [31:0] op_a, input logic [31:0] op_b,
                      input logic [31:0] x, input logic [5:0] pc, input logic eq);
    int n = 0;
    a = op_a;
    b = op_b;
    valid = 1'b1;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=ready_o_low required=accept");
    end else begin
      sb.push_back('{x: x, pc: pc, eq: eq});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    valid = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid_o && ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h required=no_output", xnor_o);
        end else begin
          e = sb.pop_front();
          check("out_xnor", xnor_o, e.x);
          check("out_popcnt", 32'(popcnt_o), 32'(e.pc));
          check("out_eq", 32'(eq_o), 32'(e.eq));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  logic [31:0] eq_vec  [6] = '{32'h0000_0000, 32'h5A5A_5A5A, 32'h8000_0001,
                               32'hFFFF_FFFF, 32'h1357_9BDF, 32'h2468_ACE0};
  logic [1:0]  sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    int n;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_xnor_o", xnor_o, 32'h0);
    check("rst_popcnt_o", 32'(popcnt_o), 32'd0);
    check("rst_eq_o", 32'(eq_o), 32'd0);
    check("rst_eq_cnt", 32'(eq_cnt_o), 32'd0);
    check("rst_sat_cnt", 32'(sat_cnt_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(ready_o), 32'd1);

    // Equal operands, two-edge latency
    send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 6'd32, 1'b1);
    valid = 1'b0;
    check("lat_edge1_valid", 32'(valid_o), 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge2_valid", 32'(valid_o), 32'd1);
    drain();
    check("cnt_after_eq", 32'(eq_cnt_o), 32'd1);
    check("sat_after_eq", 32'(sat_cnt_o), 32'd1);

    // Half-matching operands: counter unchanged
    send(32'h0000_0000, 32'hFFFF_0000, 32'h0000_FFFF, 6'd16, 1'b0);
    drain();
    check("cnt_after_neq", 32'(eq_cnt_o), 32'd1);

    // Backpressure: 5 transactions with ready low, then release
    ready = 1'b0;
    fork
      begin
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd32, 1'b1);
        send(32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFE, 6'd31, 1'b0);
        send(32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 6'd0,  1'b0);
        send(32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 6'd32, 1'b1);
        send(32'h0000_00FF, 32'h0000_0000, 32'hFFFF_FF00, 6'd24, 1'b0);
        valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        check("bp_ready_low", 32'(ready_o), 32'd0);
        check("bp_valid_hold", 32'(valid_o), 32'd1);
        check("bp_xnor_hold", xnor_o, 32'hFFFF_FFFF);
        check("bp_popcnt_hold", 32'(popcnt_o), 32'd32);
        ready = 1'b1;
        @(negedge clk);
        check("bp_ready_rise", 32'(ready_o), 32'd1);
        check("bp_no_gap", 32'(valid_o), 32'd1);
        for (int i = 1; i < 5; i++) begin
          @(negedge clk);
          check("bp_no_gap", 32'(valid_o), 32'd1);
        end
      end
    join
    drain();
    check("cnt_after_bp", 32'(eq_cnt_o), 32'd3);
    check("sat_after_bp", 32'(sat_cnt_o), 32'd3);

    // Clear, then saturation of the 2-bit counter
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("cnt_cleared", 32'(eq_cnt_o), 32'd0);
    check("sat_cleared", 32'(sat_cnt_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      send(eq_vec[i], eq_vec[i], 32'hFFFF_FFFF, 6'd32, 1'b1);
      drain();
      check("sat_step", 32'(sat_cnt_o), 32'(sat_exp[i]));
    end
    check("cnt_no_sat", 32'(eq_cnt_o), 32'd5);

    // Clear coincident with a 6th equal transfer
    send(eq_vec[5], eq_vec[5], 32'hFFFF_FFFF, 6'd32, 1'b1);
    valid = 1'b0;
    n = 0;
    while (!valid_o && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("clr_wait_valid", 32'(valid_o), 32'd1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clr_wins_sat", 32'(sat_cnt_o), 32'd0);
    check("clr_wins_cnt", 32'(eq_cnt_o), 32'd0);
    drain();

    // Mid-stream reset with two transactions in flight
    send(32'h0BAD_CAFE, 32'h0BAD_CAFE, 32'hFFFF_FFFF, 6'd32, 1'b1);
    drain();
    check("cnt_pre_rst", 32'(eq_cnt_o), 32'd1);
    send(32'h1111_1111, 32'h1111_1111, 32'hFFFF_FFFF, 6'd32, 1'b1);
    send(32'h2222_2222, 32'h2222_2223, 32'hFFFF_FFFE, 6'd31, 1'b0);
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_cnt", 32'(eq_cnt_o), 32'd0);
    check("mid_rst_sat", 32'(sat_cnt_o), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("no_stale", 32'(valid_o), 32'd0);
    end
    send(32'hCAFE_F00D, 32'hCAFE_F00D, 32'hFFFF_FFFF, 6'd32, 1'b1);
    drain();
    check("cnt_post_rst", 32'(eq_cnt_o), 32'd1);

`ifdef XNOR_CMP_MASK_EN
    m_a = 8'hF0;
    m_b = 8'h0F;
    m_mask = 8'hFF;
    m_valid = 1'b1;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mask_valid", 32'(m_valid_o), 32'd1);
    check("mask_eq", 32'(m_eq_o), 32'd1);
    check("mask_popcnt", 32'(m_popcnt_o), 32'd8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
